// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note record/replay stage.
package note_seq_pkg;

    // Top-level sequencer modes.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        PLAY = 2'd2
    } seq_state_e;

    // Sub-steps of playback: address the RAM, capture the first entry, then time notes.
    typedef enum logic [1:0] {
        PH_FETCH = 2'd0,
        PH_LOAD  = 2'd1,
        PH_RUN   = 2'd2
    } play_phase_e;

    localparam logic [7:0] KEY_SILENCE   = 8'h00;
    localparam int         DUR_W_DEFAULT = 16;
    localparam int         ENTRY_W       = 8 + DUR_W_DEFAULT;

    // One stored note at the default duration width.
    typedef struct packed {
        logic [7:0]               code;
        logic [DUR_W_DEFAULT-1:0] dur;
    } note_entry_t;

    // Entry width for an arbitrary duration field width.
    function automatic int entry_width(input int dur_w);
        return 8 + dur_w;
    endfunction

endpackage

// File: rtl/note_seq_ram.sv
// Simple dual-port note store: one write port, one registered read port, no content reset.
module note_ram
    import note_seq_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [W-1:0]             rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port plus registered read port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/note_sequencer.sv
// Record/replay stage between the keyboard decoder and the tone generator.
// Idle passes keys through, REC also stores {code, duration} entries, PLAY
// re-emits the stored notes with their original tick durations.
// Playback prefetches the next entry while the current note sounds, so notes
// must last at least two clocks (TICK_DIV >= 2).
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int DUR_W    = DUR_W_DEFAULT,
    parameter int TICK_DIV = 5000
) (
    input  logic                   clk_5MHz,
    input  logic                   reset,
    input  logic [7:0]             key_in,
    input  logic                   record,
    input  logic                   replay,
    output logic [7:0]             key_out,
    output logic                   recording,
    output logic                   replaying,
    output logic                   full,
    output logic [$clog2(DEPTH):0] note_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_width(DUR_W);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

    typedef struct packed {
        logic [7:0]       code;
        logic [DUR_W-1:0] dur;
    } note_rec_t;

    seq_state_e        state_q, state_d;
    play_phase_e       phase_q, phase_d;
    logic [PW-1:0]     pre_q, pre_d, pre_inc_s;
    logic [DUR_W-1:0]  dur_q, dur_d, dur_inc_s, dur_wr_s;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic [7:0]        cur_code_q, cur_code_d;
    logic [CW-1:0]     idx_q, idx_d, idx_nxt_s;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        key_q, key_d;
    logic              replay_q;
    logic              rec_flag_q, play_flag_q, full_q;
    logic              tick_s, full_s, boundary_s;
    logic              wr_en_s;
    logic [AW-1:0]     wr_addr_s, rd_addr_s;
    logic [EW-1:0]     wr_data_s, rd_data_s;
    note_rec_t         rd_entry_s;

    note_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk_i     (clk_5MHz),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (wr_addr_s),
        .wr_data_i (wr_data_s),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (rd_data_s)
    );

    assign rd_entry_s = rd_data_s;
    assign tick_s     = (pre_q == PW'(TICK_DIV - 1));
    assign pre_inc_s  = tick_s ? '0 : pre_q + PW'(1);
    assign full_s     = (count_q == CW'(DEPTH));
    assign idx_nxt_s  = idx_q + CW'(1);
    assign wr_addr_s  = count_q[AW-1:0];
    assign wr_data_s  = {cur_code_q, dur_wr_s};

    // Saturating tick count of the note being recorded; a stored entry is never zero ticks.
    always_comb begin
        dur_inc_s = dur_q;
        if (tick_s && (dur_q != DUR_MAX)) begin
            dur_inc_s = dur_q + DUR_W'(1);
        end else begin
            dur_inc_s = dur_q;
        end
        dur_wr_s = (dur_inc_s == '0) ? DUR_W'(1) : dur_inc_s;
    end

    // Next-state logic for mode, prescaler, recording and playback bookkeeping.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        pre_d      = pre_q;
        dur_d      = dur_q;
        rem_d      = rem_q;
        cur_code_d = cur_code_q;
        idx_d      = idx_q;
        count_d    = count_q;
        key_d      = key_q;
        wr_en_s    = 1'b0;
        boundary_s = 1'b0;
        rd_addr_s  = idx_nxt_s[AW-1:0];

        case (state_q)
            IDLE: begin
                key_d = key_in;
                pre_d = '0;
                if (record) begin
                    state_d    = REC;
                    count_d    = '0;
                    cur_code_d = key_in;
                    dur_d      = '0;
                end else if (replay && !replay_q) begin
                    state_d = PLAY;
                    phase_d = PH_FETCH;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            REC: begin
                key_d      = key_in;
                pre_d      = pre_inc_s;
                dur_d      = dur_inc_s;
                boundary_s = !record || (key_in != cur_code_q) || (dur_inc_s == DUR_MAX);
                if (boundary_s) begin
                    // Close the current entry; a full store keeps timing but drops the write.
                    pre_d      = '0;
                    dur_d      = '0;
                    cur_code_d = key_in;
                    if (!full_s) begin
                        wr_en_s = 1'b1;
                        count_d = count_q + CW'(1);
                    end else begin
                        count_d = count_q;
                    end
                    if (!record) begin
                        state_d = IDLE;
                    end else begin
                        state_d = REC;
                    end
                end else begin
                    state_d = REC;
                end
            end

            PLAY: begin
                if (!replay) begin
                    state_d = IDLE;
                    key_d   = KEY_SILENCE;
                end else begin
                    case (phase_q)
                        PH_FETCH: begin
                            rd_addr_s = idx_q[AW-1:0];
                            key_d     = KEY_SILENCE;
                            if (count_q == '0) begin
                                state_d = IDLE;
                            end else begin
                                phase_d = PH_LOAD;
                            end
                        end
                        PH_LOAD: begin
                            key_d   = rd_entry_s.code;
                            rem_d   = rd_entry_s.dur;
                            pre_d   = '0;
                            phase_d = PH_RUN;
                        end
                        PH_RUN: begin
                            pre_d = pre_inc_s;
                            if (tick_s && (rem_q == DUR_W'(1))) begin
                                // Note finished: the prefetched next entry is already on rd_data.
                                idx_d = idx_nxt_s;
                                if (idx_nxt_s == count_q) begin
                                    state_d = IDLE;
                                    key_d   = KEY_SILENCE;
                                end else begin
                                    key_d = rd_entry_s.code;
                                    rem_d = rd_entry_s.dur;
                                end
                            end else if (tick_s) begin
                                rem_d = rem_q - DUR_W'(1);
                            end else begin
                                rem_d = rem_q;
                            end
                        end
                        default: begin
                            phase_d = PH_FETCH;
                        end
                    endcase
                end
            end

            default: begin
                state_d = IDLE;
                key_d   = KEY_SILENCE;
            end
        endcase
    end

    // State register, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk_5MHz) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= PH_FETCH;
            pre_q       <= '0;
            dur_q       <= '0;
            rem_q       <= '0;
            cur_code_q  <= KEY_SILENCE;
            idx_q       <= '0;
            count_q     <= '0;
            key_q       <= KEY_SILENCE;
            replay_q    <= 1'b0;
            rec_flag_q  <= 1'b0;
            play_flag_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pre_q       <= pre_d;
            dur_q       <= dur_d;
            rem_q       <= rem_d;
            cur_code_q  <= cur_code_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            key_q       <= key_d;
            replay_q    <= replay;
            rec_flag_q  <= (state_d == REC);
            play_flag_q <= (state_d == PLAY);
            full_q      <= (count_d == CW'(DEPTH));
        end
    end

    assign key_out    = key_q;
    assign recording  = rec_flag_q;
    assign replaying  = play_flag_q;
    assign full       = full_q;
    assign note_count = count_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with TICK_DIV=4, DUR_W=4, DEPTH=4.
module tb_note_sequencer;

    localparam int DEPTH    = 4;
    localparam int DUR_W    = 4;
    localparam int TICK_DIV = 4;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk_5MHz = 1'b0;
    logic          reset;
    logic [7:0]    key_in;
    logic          record;
    logic          replay;
    logic [7:0]    key_out;
    logic          recording;
    logic          replaying;
    logic          full;
    logic [CW-1:0] note_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [7:0] code;
        int         dur;
    } note_t;

    logic [7:0] exp_q [$];
    note_t      notes [$];

    note_sequencer #(
        .DEPTH    (DEPTH),
        .DUR_W    (DUR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk_5MHz   (clk_5MHz),
        .reset      (reset),
        .key_in     (key_in),
        .record     (record),
        .replay     (replay),
        .key_out    (key_out),
        .recording  (recording),
        .replaying  (replaying),
        .full       (full),
        .note_count (note_count)
    );

    always #5 clk_5MHz = ~clk_5MHz;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs and return just after the clock edge.
    task automatic drive(input logic [7:0] k, input logic rec, input logic rep);
        key_in = k;
        record = rec;
        replay = rep;
        @(posedge clk_5MHz);
        #1;
    endtask

    // Hold a key while recording; key_out must follow key_in one cycle later.
    task automatic rec_seg(input logic [7:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(code);
            drive(code, 1'b1, 1'b0);
            check_eq("pass_rec", 32'(key_out), 32'(exp_q.pop_front()));
            check_eq("rec_flag", 32'(recording), 32'd1);
        end
    endtask

    // Drop record: final flush cycle, back to IDLE.
    task automatic rec_stop(input int exp_count);
        drive(8'h00, 1'b0, 1'b0);
        check_eq("stop_key", 32'(key_out), 32'd0);
        check_eq("stop_rec_flag", 32'(recording), 32'd0);
        check_eq("note_count", 32'(note_count), 32'(exp_count));
    endtask

    // Start playback and compare every output cycle against the expected note stream.
    task automatic play_check();
        int waited;
        exp_q.delete();
        foreach (notes[i]) begin
            for (int c = 0; c < notes[i].dur * TICK_DIV; c++) begin
                exp_q.push_back(notes[i].code);
            end
        end
        exp_q.push_back(8'h00);
        drive(8'h00, 1'b0, 1'b1);
        waited = 0;
        while (key_out === 8'h00 && waited < 6) begin
            drive(8'h00, 1'b0, 1'b1);
            waited++;
        end
        check_eq("play_start", 32'(waited < 6), 32'd1);
        while (exp_q.size() > 1) begin
            check_eq("play_key", 32'(key_out), 32'(exp_q.pop_front()));
            check_eq("play_flag", 32'(replaying), 32'd1);
            drive(8'h00, 1'b0, 1'b1);
        end
        check_eq("play_end_key", 32'(key_out), 32'(exp_q.pop_front()));
        check_eq("play_end_flag", 32'(replaying), 32'd0);
        drive(8'h00, 1'b0, 1'b0);
    endtask

    // Start playback and wait (bounded) until the first note sounds.
    task automatic play_start_wait();
        int waited;
        drive(8'h00, 1'b0, 1'b1);
        waited = 0;
        while (key_out === 8'h00 && waited < 6) begin
            drive(8'h00, 1'b0, 1'b1);
            waited++;
        end
        check_eq("play_start", 32'(waited < 6), 32'd1);
    endtask

    initial begin
        reset  = 1'b1;
        key_in = 8'h33;
        record = 1'b0;
        replay = 1'b0;
        @(posedge clk_5MHz);
        #1;
        drive(8'h33, 1'b0, 1'b0);
        check_eq("rst_key", 32'(key_out), 32'd0);
        check_eq("rst_recording", 32'(recording), 32'd0);
        check_eq("rst_replaying", 32'(replaying), 32'd0);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_count", 32'(note_count), 32'd0);
        reset = 1'b0;

        // Passthrough in IDLE
        begin
            logic [7:0] pt [4];
            pt = '{8'h41, 8'h00, 8'h7F, 8'h00};
            foreach (pt[i]) begin
                exp_q.push_back(pt[i]);
                drive(pt[i], 1'b0, 1'b0);
                check_eq("pass_idle", 32'(key_out), 32'(exp_q.pop_front()));
            end
        end

        // Record three notes and replay them
        rec_seg(8'h41, 12);
        rec_seg(8'h00, 8);
        rec_seg(8'h5A, 20);
        rec_stop(3);
        check_eq("full_3", 32'(full), 32'd0);
        notes.delete();
        notes.push_back('{code: 8'h41, dur: 3});
        notes.push_back('{code: 8'h00, dur: 2});
        notes.push_back('{code: 8'h5A, dur: 5});
        play_check();

        // Duration saturation splits a long note into two entries
        rec_seg(8'h51, 70);
        rec_stop(2);
        notes.delete();
        notes.push_back('{code: 8'h51, dur: 15});
        notes.push_back('{code: 8'h51, dur: 2});
        play_check();

        // Full store: six notes recorded, four kept
        for (int i = 0; i < 6; i++) begin
            rec_seg(8'h11 + 8'(i), 8);
        end
        check_eq("full_flag", 32'(full), 32'd1);
        check_eq("full_count", 32'(note_count), 32'd4);
        rec_stop(4);
        check_eq("full_after_stop", 32'(full), 32'd1);
        notes.delete();
        for (int i = 0; i < 4; i++) begin
            notes.push_back('{code: 8'h11 + 8'(i), dur: 2});
        end
        play_check();

        // Abort playback mid-note
        play_start_wait();
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b1);
        check_eq("abort_mid_key", 32'(key_out), 32'h11);
        drive(8'h00, 1'b0, 1'b0);
        check_eq("abort_key", 32'(key_out), 32'd0);
        check_eq("abort_flag", 32'(replaying), 32'd0);
        drive(8'h00, 1'b0, 1'b0);

        // record and replay rising together: record wins
        drive(8'h22, 1'b1, 1'b1);
        check_eq("prio_rec", 32'(recording), 32'd1);
        check_eq("prio_play", 32'(replaying), 32'd0);
        check_eq("prio_key", 32'(key_out), 32'h22);
        rec_seg(8'h22, 7);
        rec_stop(1);

        // Reset in the middle of playback
        play_start_wait();
        check_eq("pre_reset_key", 32'(key_out), 32'h22);
        drive(8'h00, 1'b0, 1'b1);
        reset = 1'b1;
        drive(8'h00, 1'b0, 1'b1);
        check_eq("rst_play_key", 32'(key_out), 32'd0);
        check_eq("rst_play_count", 32'(note_count), 32'd0);
        check_eq("rst_play_flag", 32'(replaying), 32'd0);
        reset = 1'b0;
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b1);
        check_eq("empty_key0", 32'(key_out), 32'd0);
        drive(8'h00, 1'b0, 1'b1);
        check_eq("empty_key1", 32'(key_out), 32'd0);
        check_eq("empty_idle", 32'(replaying), 32'd0);
        drive(8'h00, 1'b0, 1'b1);
        check_eq("empty_key2", 32'(key_out), 32'd0);
        check_eq("empty_stay_idle", 32'(replaying), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
